// File: rtl/cache_req_arbiter.sv
// N-port front end for the single cache CPU-request interface: arbitrates, latches
// the winning request, holds it until the cache completes, and returns the response to its owner.
module cache_req_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1,
  localparam int GW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                      sys_clk,
  input  logic                      rstn,
  input  logic [N_PORTS*ADDR_W-1:0] port_req_addr,
  input  logic [N_PORTS*DATA_W-1:0] port_req_data,
  input  logic [N_PORTS-1:0]        port_req_rw,
  input  logic [N_PORTS-1:0]        port_req_valid,
  output logic [N_PORTS*DATA_W-1:0] port_res_data,
  output logic [N_PORTS-1:0]        port_res_ready,
  output logic [ADDR_W-1:0]         cache_req_addr,
  output logic [DATA_W-1:0]         cache_req_data,
  output logic                      cache_req_rw,
  output logic                      cache_req_valid,
  input  logic [DATA_W-1:0]         cache_res_data,
  input  logic                      cache_res_ready,
  output logic [GW-1:0]             grant_idx,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [GW-1:0]             ptr_q, ptr_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic                      rw_q, rw_d;
  logic [N_PORTS*DATA_W-1:0] res_data_q, res_data_d;

  logic          win_vld;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;
  logic          found;
  int            rr_sum;

  // Winner search: round-robin starts one past the last served port, fixed picks lowest index.
  always_comb begin
    win_vld = |port_req_valid;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    rr_sum  = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N_PORTS; k++) begin
        rr_sum = (int'(ptr_q) + k) % N_PORTS;
        cand   = GW'(rr_sum);
        if (!found && port_req_valid[cand]) begin
          found   = 1'b1;
          win_idx = cand;
        end
      end
    end else begin
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        cand = GW'(k);
        if (port_req_valid[cand]) win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rw_d       = rw_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          addr_d  = port_req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          data_d  = port_req_data[int'(win_idx)*DATA_W +: DATA_W];
          rw_d    = port_req_rw[win_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cache_res_ready) begin
          res_data_d[int'(grant_q)*DATA_W +: DATA_W] = cache_res_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RR_MODE != 0) ptr_d = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ptr_q      <= GW'(N_PORTS - 1);
      grant_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      res_data_q <= res_data_d;
    end
  end

  logic [N_PORTS-1:0] one_hot;

  always_comb begin
    one_hot = '0;
    one_hot[grant_q] = 1'b1;
  end

  assign port_res_ready  = (state_q == ST_RESP) ? one_hot : '0;
  assign port_res_data   = res_data_q;
  assign cache_req_addr  = addr_q;
  assign cache_req_data  = data_q;
  assign cache_req_rw    = rw_q;
  assign cache_req_valid = (state_q == ST_ISSUE);
  assign grant_idx       = grant_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- N-port front-end to the single CPU-request interface of the set-associative cache (addr/data/rw/valid in; data/ready out).
- Several masters (e.g. instruction fetch, load/store, debug loader) share one cache without external muxing.
- Serialises requests under a selectable arbitration policy, latches the winning request, holds it to the cache until the cache responds, and routes the response back to the originating port only.

Parameters:
N_PORTS, 2, number of requestor ports (2..8)
ADDR_W, 27, request address width
DATA_W, 32, request/response data width
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest port index wins)

Ports:
sys_clk  in  1  single clock
rstn  in  1  reset; asynchronous, active-low
port_req_addr  in  N_PORTS*ADDR_W  per-port address, port i in bits [i*ADDR_W +: ADDR_W]
port_req_data  in  N_PORTS*DATA_W  per-port write data, same packing
port_req_rw  in  N_PORTS  per-port 1 = write, 0 = read
port_req_valid  in  N_PORTS  per-port request; level, held until that port's res_ready
port_res_data  out  N_PORTS*DATA_W  per-port response data
port_res_ready  out  N_PORTS  per-port one-cycle completion pulse
cache_req_addr  out  ADDR_W  request to cache
cache_req_data  out  DATA_W  request to cache
cache_req_rw  out  1  request to cache
cache_req_valid  out  1  request to cache; level
cache_res_data  in  DATA_W  cache response data
cache_res_ready  in  1  cache completion pulse
grant_idx  out  $clog2(N_PORTS) (min 1)  port currently owning the cache
busy  out  1  high in ISSUE and RESP

Behaviour:
- Reset (rstn low, async): state IDLE. All outputs 0 (cache_req_*, cache_req_valid, port_res_ready, port_res_data, grant_idx, busy). RR pointer = N_PORTS-1, so port 0 has first priority.
- Reset mid-transaction: everything clears immediately and the in-flight response is lost. The cache must be reset with the same rstn.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If port_req_valid has no bits set, stay in IDLE.
  - Otherwise select a winner g. RR_MODE=1: first set bit searching from ptr+1 upward, modulo N_PORTS. RR_MODE=0: lowest set index.
  - Latch port g's addr/data/rw into cache_req_* and set grant_idx = g. Go to ISSUE.
- ISSUE:
  - cache_req_valid = 1, busy = 1. cache_req_* held stable; requestor inputs are ignored.
  - On cache_res_ready: capture cache_res_data into slot g of port_res_data and go to RESP.
  - cache_req_valid drops on the same edge, so the cache never sees valid high in the cycle after its ready.
- RESP:
  - port_res_ready[g] = 1 for exactly this cycle; all other bits 0. cache_req_valid = 0, busy = 1.
  - RR_MODE=1: ptr <= g. Next state IDLE.
- Latency:
  - Valid seen in IDLE at cycle t -> cache_req_valid high at t+1.
  - cache_res_ready at cycle r -> port_res_ready pulse at r+1.
  - Next arbitration at r+2, so there are at least 2 valid-low cycles between back-to-back cache transactions.
- Requestor rules:
  - Requestor deasserts valid on the edge ending its res_ready cycle. A valid still high in the following IDLE cycle counts as a new request.
  - Valid dropped during ISSUE has no effect: the transaction completes and the pulse is still delivered.
- port_res_data: each slot holds its last response until that port's next completion; other slots never change.
- Simultaneous requests: exactly one grant per arbitration. Losers keep valid high and are served later.
  - RR_MODE=1: with all ports continuously requesting, grant order is 0,1,…,N-1,0,…
  - RR_MODE=0: a continuously requesting port 0 starves the others. This is the intended behaviour.
- cache_res_ready outside ISSUE: ignored.

Test Plan:
- Reset, N_PORTS=2, RR_MODE=1. Port 0 read addr 0x0000100 at t=0. Cache answers 0xDEADBEEF at t=5 -> cache_req_valid high t=1..5 with addr 0x0000100, rw 0; port_res_ready[0] pulses at t=6; port_res_data slot0 = 0xDEADBEEF; slot1 stays 0.
- Both ports request continuously, RR_MODE=1, cache latency 3 -> grants alternate 0,1,0,1; each port gets exactly 2 pulses over 4 transactions; ≥2 valid-low cycles between transactions.
- Same stimulus with RR_MODE=0 -> 4 consecutive grants to port 0; port 1 gets no pulse until port 0 drops valid.
- N_PORTS=4, RR_MODE=1. Ports 1 and 3 request after a completion on port 3 -> port 1 wins (pointer wrap); grant_idx=1.
- Port 1 write data 0x12345678 addr 0x7FFFFFF. Port 1 drops valid during ISSUE -> cache_req_* stay stable; pulse still on port_res_ready[1].
- rstn low during ISSUE -> cache_req_valid, busy, grant_idx go to 0 immediately (asynchronous). After release, a pending request on port 0 is granted first (pointer reset).
